// File: rtl/vga_sync_gen_pkg.sv
// Shared timing defaults, FSM encodings and a window-compare helper for the
// VGA sync generator.
`timescale 1ns/1ps
package vga_sync_gen_pkg;

  // All row/column counters are this wide; totals above 2**CNT_W cannot be represented.
  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  // 640x480 @ 60 Hz timing with a 25 MHz pixel clock
  localparam int DEF_TOTAL_COLS      = 800;
  localparam int DEF_TOTAL_ROWS      = 525;
  localparam int DEF_ACTIVE_COLS     = 640;
  localparam int DEF_ACTIVE_ROWS     = 480;
  localparam int DEF_H_FRONT_PORCH   = 16;
  localparam int DEF_H_SYNC_WIDTH    = 96;
  localparam int DEF_V_FRONT_PORCH   = 10;
  localparam int DEF_V_SYNC_WIDTH    = 2;
  localparam int DEF_SYNC_ACTIVE_LOW = 1;

  // FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_FINISH = 2'b10;

  // Inclusive range test used by the pulse window decoders
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_sync_window_decode.sv
// Registered window comparator: drives the connector sync pulse while the
// (next-cycle) count lies in [START, START+WIDTH-1], at the chosen polarity.
`timescale 1ns/1ps
module sync_window_decode
  import vga_sync_gen_pkg::*;
#(
  parameter int START      = 656,
  parameter int WIDTH      = 96,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_En,
  input  logic [CNT_W-1:0] i_Count,
  output logic             o_Pulse
);

  localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(START);
  localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(START + WIDTH - 1);
  localparam logic             IDLE_LVL = ACTIVE_LOW;

  logic asserted;
  logic pulse_d;
  logic pulse_q;

  // Decode the window and map it to the connector polarity
  always_comb begin
    asserted = i_En && in_window(i_Count, WIN_LO, WIN_HI);
    pulse_d  = asserted ? ~IDLE_LVL : IDLE_LVL;
  end

  // Register the pulse; reset parks it at the deasserted level
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) pulse_q <= IDLE_LVL;
    else          pulse_q <= pulse_d;
  end

  assign o_Pulse = pulse_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync source: column/row counters under a small IDLE/RUN/FINISH FSM,
// raw active-region syncs, porch-adjusted connector pulses, strobes and a
// frame counter. Every output is registered and decoded from next-cycle
// counts so all of them describe the pixel shown on o_Col_Count/o_Row_Count.
//
//   state  | meaning
//   IDLE   | counters parked at 0, outputs at reset levels, frame count held
//   RUN    | free-running raster, enable high
//   FINISH | enable dropped; finish the current frame, then IDLE (or back to RUN)
`timescale 1ns/1ps
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int TOTAL_COLS      = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS      = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS     = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS     = DEF_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
  parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
  parameter int SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Enable,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_HSync_Pulse,
  output logic             o_VSync_Pulse,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Active,
  output logic             o_Line_Start,
  output logic             o_Frame_Start,
  output logic [7:0]       o_Frame_Count,
  output logic             o_Running
);

  // Bad timing parameters stop elaboration rather than producing a silently broken raster
  if (TOTAL_COLS > MAX_TOTAL || TOTAL_ROWS > MAX_TOTAL) begin : g_bad_total
    $error("vga_sync_gen: TOTAL_COLS/TOTAL_ROWS exceed counter range");
  end
  if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h
    $error("vga_sync_gen: horizontal active+porch+sync exceeds TOTAL_COLS");
  end
  if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v
    $error("vga_sync_gen: vertical active+porch+sync exceeds TOTAL_ROWS");
  end

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] ACT_COLS = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0] ACT_ROWS = CNT_W'(ACTIVE_ROWS);

  logic [1:0]       state_d,     state_q;
  logic [CNT_W-1:0] col_d,       col_q;
  logic [CNT_W-1:0] row_d,       row_q;
  logic [7:0]       frame_cnt_d, frame_cnt_q;
  logic             running_d,   running_q;
  logic             hsync_d,     hsync_q;
  logic             vsync_d,     vsync_q;
  logic             active_d,    active_q;
  logic             line_st_d,   line_st_q;
  logic             frame_st_d,  frame_st_q;
  logic             last_col, last_row, frame_end;

  // Next state, next counts and frame counter
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    frame_cnt_d = frame_cnt_q;
    last_col    = (col_q == LAST_COL);
    last_row    = (row_q == LAST_ROW);
    frame_end   = last_col && last_row;

    case (state_q)
      ST_IDLE: begin
        col_d = '0;
        row_d = '0;
        if (i_Enable) state_d = ST_RUN;
      end
      ST_RUN, ST_FINISH: begin
        col_d = last_col ? '0 : col_q + 1'b1;
        if (last_col) row_d = last_row ? '0 : row_q + 1'b1;
        if (frame_end) frame_cnt_d = frame_cnt_q + 8'd1;
        // An enable drop on the last pixel in RUN still lands in FINISH,
        // which then plays out one more full frame.
        if (state_q == ST_RUN) begin
          if (!i_Enable) state_d = ST_FINISH;
        end else begin
          if (i_Enable)       state_d = ST_RUN;
          else if (frame_end) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // Flags decoded from next-cycle counts so they line up with the count outputs
  always_comb begin
    running_d  = (state_d != ST_IDLE);
    hsync_d    = running_d && (col_d < ACT_COLS);
    vsync_d    = running_d && (row_d < ACT_ROWS);
    active_d   = hsync_d && vsync_d;
    line_st_d  = running_d && (col_d == '0);
    frame_st_d = line_st_d && (row_d == '0);
  end

  // State, counter and flag registers
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      frame_cnt_q <= '0;
      running_q   <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      active_q    <= 1'b0;
      line_st_q   <= 1'b0;
      frame_st_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      frame_cnt_q <= frame_cnt_d;
      running_q   <= running_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      active_q    <= active_d;
      line_st_q   <= line_st_d;
      frame_st_q  <= frame_st_d;
    end
  end

  sync_window_decode #(
    .START      (ACTIVE_COLS + H_FRONT_PORCH),
    .WIDTH      (H_SYNC_WIDTH),
    .ACTIVE_LOW (SYNC_ACTIVE_LOW != 0)
  ) u_h_win (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_En    (running_d),
    .i_Count (col_d),
    .o_Pulse (o_HSync_Pulse)
  );

  // V window depends on row only
  sync_window_decode #(
    .START      (ACTIVE_ROWS + V_FRONT_PORCH),
    .WIDTH      (V_SYNC_WIDTH),
    .ACTIVE_LOW (SYNC_ACTIVE_LOW != 0)
  ) u_v_win (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_En    (running_d),
    .i_Count (row_d),
    .o_Pulse (o_VSync_Pulse)
  );

  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_Line_Start  = line_st_q;
  assign o_Frame_Start = frame_st_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Frame_Count = frame_cnt_q;
  assign o_Running     = running_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a shrunken 20x10 raster:
// active 12x6, H pulse on cols 14..16, V pulse on rows 7..8, 200 clocks/frame.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  localparam int TC = 20, TR = 10, AC = 12, AR = 6;
  localparam int HFP = 2, HSW = 3, VFP = 1, VSW = 2;
  localparam int H_LO = AC + HFP, H_HI = AC + HFP + HSW - 1;  // 14..16
  localparam int V_LO = AR + VFP, V_HI = AR + VFP + VSW - 1;  // 7..8
  localparam int FRAME = TC * TR;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Enable = 1'b0;
  logic       o_HSync, o_VSync, o_HSync_Pulse, o_VSync_Pulse;
  logic [9:0] o_Col_Count, o_Row_Count;
  logic       o_Active, o_Line_Start, o_Frame_Start, o_Running;
  logic [7:0] o_Frame_Count;

  int errors = 0;
  int checks = 0;

  always #5 i_Clk = ~i_Clk;

  vga_sync_gen #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .V_FRONT_PORCH(VFP),
    .V_SYNC_WIDTH(VSW), .SYNC_ACTIVE_LOW(1)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Enable(i_Enable),
    .o_HSync(o_HSync), .o_VSync(o_VSync),
    .o_HSync_Pulse(o_HSync_Pulse), .o_VSync_Pulse(o_VSync_Pulse),
    .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count),
    .o_Active(o_Active), .o_Line_Start(o_Line_Start),
    .o_Frame_Start(o_Frame_Start), .o_Frame_Count(o_Frame_Count),
    .o_Running(o_Running)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic chk_idle(input string tag, input int fc);
    chk({tag, ".col"},     32'(o_Col_Count),   0);
    chk({tag, ".row"},     32'(o_Row_Count),   0);
    chk({tag, ".hsync"},   32'(o_HSync),       0);
    chk({tag, ".vsync"},   32'(o_VSync),       0);
    chk({tag, ".active"},  32'(o_Active),      0);
    chk({tag, ".hpulse"},  32'(o_HSync_Pulse), 1);
    chk({tag, ".vpulse"},  32'(o_VSync_Pulse), 1);
    chk({tag, ".lstart"},  32'(o_Line_Start),  0);
    chk({tag, ".fstart"},  32'(o_Frame_Start), 0);
    chk({tag, ".fcount"},  32'(o_Frame_Count), 32'(fc));
    chk({tag, ".running"}, 32'(o_Running),     0);
  endtask

  task automatic chk_run(input string tag, input int c, input int r, input int fc);
    chk({tag, ".col"},     32'(o_Col_Count),   32'(c));
    chk({tag, ".row"},     32'(o_Row_Count),   32'(r));
    chk({tag, ".hsync"},   32'(o_HSync),       32'(c < AC));
    chk({tag, ".vsync"},   32'(o_VSync),       32'(r < AR));
    chk({tag, ".active"},  32'(o_Active),      32'(c < AC && r < AR));
    chk({tag, ".hpulse"},  32'(o_HSync_Pulse), 32'(!(c >= H_LO && c <= H_HI)));
    chk({tag, ".vpulse"},  32'(o_VSync_Pulse), 32'(!(r >= V_LO && r <= V_HI)));
    chk({tag, ".lstart"},  32'(o_Line_Start),  32'(c == 0));
    chk({tag, ".fstart"},  32'(o_Frame_Start), 32'(c == 0 && r == 0));
    chk({tag, ".fcount"},  32'(o_Frame_Count), 32'(fc));
    chk({tag, ".running"}, 32'(o_Running),     1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hp_low, fs_cnt, fs_first, fs_second;

    // Reset for 5 clocks, then idle with enable low
    step(5);
    chk_idle("reset", 0);
    i_Rst_L = 1'b1;
    step(100);
    chk_idle("idle", 0);

    // Enable: two full frames, every cycle checked against the raster
    i_Enable = 1'b1;
    step(1);
    hp_low = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      chk_run("run", k % TC, (k / TC) % TR, k / FRAME);
      if (k < TC && !o_HSync_Pulse) hp_low++;
      if (o_Frame_Start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k; else if (fs_second < 0) fs_second = k;
      end
      step(1);
    end
    chk("hpulse_width", 32'(hp_low), HSW);
    chk("fstart_count", 32'(fs_cnt), 2);
    chk("fstart_period", 32'(fs_second - fs_first), FRAME);

    // Graceful stop: drop enable at row 2, frame finishes, then IDLE
    step(40);
    chk_run("stop_r2", 0, 2, 2);
    i_Enable = 1'b0;
    step(1);
    chk_run("finish", 1, 2, 2);
    step(158);
    chk_run("finish_last", TC - 1, TR - 1, 2);
    step(1);
    chk_idle("stopped", 3);
    step(5);
    chk_idle("stopped_hold", 3);

    // Re-enable while in FINISH: no discontinuity
    i_Enable = 1'b1;
    step(1);
    chk_run("restart", 0, 0, 3);
    step(40);
    i_Enable = 1'b0;
    step(1);
    chk_run("fin2", 1, 2, 3);
    step(59);
    chk_run("fin2_r5", 0, 5, 3);
    i_Enable = 1'b1;
    step(1);
    chk_run("rerun", 1, 5, 3);
    step(98);
    chk_run("rerun_last", TC - 1, TR - 1, 3);
    step(1);
    chk_run("rerun_wrap", 0, 0, 4);

    // Enable drop exactly on the last pixel: one more full frame in FINISH
    step(FRAME - 1);
    chk_run("edge_last", TC - 1, TR - 1, 4);
    i_Enable = 1'b0;
    step(1);
    chk_run("edge_wrap", 0, 0, 5);
    step(FRAME - 1);
    chk_run("edge_fin_last", TC - 1, TR - 1, 5);
    step(1);
    chk_idle("edge_idle", 6);

    // Reset mid-frame at col 7 / row 3
    i_Enable = 1'b1;
    step(1);
    chk_run("pre_rst", 0, 0, 6);
    step(3 * TC + 7);
    chk_run("mid", 7, 3, 6);
    i_Rst_L = 1'b0;
    step(1);
    chk_idle("mid_rst", 0);
    i_Rst_L = 1'b1;
    step(1);
    chk_run("post_rst", 0, 0, 0);

    // Frame counter wrap 255 -> 0
    step(FRAME * 255);
    chk_run("fc255", 0, 0, 255);
    step(FRAME - 1);
    chk_run("fc255_last", TC - 1, TR - 1, 255);
    step(1);
    chk_run("fc_wrap", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
